// File: rtl/dual_port_memory_pkg.sv
// Shared definitions for the byte-enable dual-port memory family.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package dual_port_memory_pkg;

  // Accepted values of the COLLISION_MODE parameter.
  localparam string COLLISION_WRITE_FIRST = "WRITE_FIRST";
  localparam string COLLISION_READ_FIRST  = "READ_FIRST";

  localparam int MIN_READ_LATENCY = 1;
  localparam int MAX_READ_LATENCY = 3;

  // Controller states: RST while reset is held, CLEAR during the zero-fill
  // sweep, RUN once requests are accepted.
  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2
  } mem_state_e;

  // Returns the number of byte lanes, or 0 when the geometry or the read
  // latency is not supported.
  function automatic int num_bytes_checked(input int mem_width,
                                           input int byte_width,
                                           input int mem_depth,
                                           input int read_latency);
    if (mem_width <= 0 || byte_width <= 0) return 0;
    if ((mem_width % byte_width) != 0) return 0;
    if (mem_depth < 2) return 0;
    if (read_latency < MIN_READ_LATENCY || read_latency > MAX_READ_LATENCY) return 0;
    return mem_width / byte_width;
  endfunction

endpackage

// File: rtl/memory_read_pipeline.sv
// Delay chain for read responses: STAGES register stages carrying {valid, data}.
// Latency: STAGES clock edges; one response accepted per cycle.
// Backpressure: none, the chain always advances; only valid bits are reset.
//
// Ports:
//   clk_i, rst_i      clock and asynchronous active-high reset (valid bits only)
//   vld_i, dat_i      response entering the chain
//   vld_o, dat_o      response leaving the chain; dat_o holds when vld_o is low
module memory_read_pipeline #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] dat_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] dat_o
);

  logic [STAGES-1:0]             vld_q;
  logic [STAGES-1:0][WIDTH-1:0]  dat_q;

  // Index s of these vectors is what stage s loads from: index 0 is the
  // chain input, index s>0 is the previous stage.
  logic [STAGES:0]               vld_in_c;
  logic [STAGES:0][WIDTH-1:0]    dat_in_c;

  assign vld_in_c = {vld_q, vld_i};
  assign dat_in_c = {dat_q, dat_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_in_c[STAGES-1:0];
    end
  end

  // Data only moves with a valid response, so the last stage keeps the most
  // recent word while the chain is idle.
  always_ff @(posedge clk_i) begin
    for (int s = 0; s < STAGES; s++) begin
      if (vld_in_c[s]) begin
        dat_q[s] <= dat_in_c[s];
      end
    end
  end

  assign vld_o = vld_q[STAGES-1];
  assign dat_o = dat_q[STAGES-1];

endmodule

// File: rtl/byte_enable_dual_port_memory.sv
// One-write/one-read RAM with byte-lane write enables, selectable same-address
// collision behaviour and an optional zero-fill sweep after reset.
// Latency: READ_LATENCY (1..3) edges from read request to DATA_OUT_VALID.
// Backpressure: READY low during reset and clear; requests then are dropped.
//
// Ports:
//   CLK, RESET                      clock, asynchronous active-high reset
//   WRITE_ADDRESS, DATA_IN,
//   WRITE_ENABLE, BYTE_ENABLE       write port; BYTE_ENABLE[i] gates lane i
//   READ_ADDRESS, READ_ENABLE       read request
//   DATA_OUT, DATA_OUT_VALID        read response, valid is a one-cycle strobe
//   READY                           high while requests are being accepted
module byte_enable_dual_port_memory
  import dual_port_memory_pkg::*;
#(
  parameter int    MEMORY_WIDTH   = 512,
  parameter int    MEMORY_DEPTH   = 512,
  parameter int    BYTE_WIDTH     = 8,
  parameter int    READ_LATENCY   = 1,
  parameter string COLLISION_MODE = "WRITE_FIRST",
  parameter bit    CLEAR_ON_RESET = 1'b1,
  parameter string INIT_FILE      = "",
  localparam int   ADDRESS_WIDTH  = $clog2(MEMORY_DEPTH),
  localparam int   NUM_BYTES      = MEMORY_WIDTH / BYTE_WIDTH
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [ADDRESS_WIDTH-1:0] WRITE_ADDRESS,
  input  logic [MEMORY_WIDTH-1:0]  DATA_IN,
  input  logic                     WRITE_ENABLE,
  input  logic [NUM_BYTES-1:0]     BYTE_ENABLE,
  input  logic [ADDRESS_WIDTH-1:0] READ_ADDRESS,
  input  logic                     READ_ENABLE,
  output logic [MEMORY_WIDTH-1:0]  DATA_OUT,
  output logic                     DATA_OUT_VALID,
  output logic                     READY
);

  localparam int NUM_BYTES_CHECKED =
    num_bytes_checked(MEMORY_WIDTH, BYTE_WIDTH, MEMORY_DEPTH, READ_LATENCY);
  localparam bit WRITE_FIRST_MODE = (COLLISION_MODE == COLLISION_WRITE_FIRST);
  localparam bit READ_FIRST_MODE  = (COLLISION_MODE == COLLISION_READ_FIRST);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(MEMORY_DEPTH - 1);

  if (NUM_BYTES_CHECKED == 0) begin : g_bad_geometry
    $error("byte_enable_dual_port_memory: MEMORY_WIDTH must be a multiple of BYTE_WIDTH, MEMORY_DEPTH >= 2, READ_LATENCY in 1..3");
  end
  if (!(WRITE_FIRST_MODE || READ_FIRST_MODE)) begin : g_bad_collision_mode
    $error("byte_enable_dual_port_memory: COLLISION_MODE must be WRITE_FIRST or READ_FIRST");
  end

  // ---------------------------------------------------------------------------
  // Controller: RST -> (CLEAR ->) RUN
  // ---------------------------------------------------------------------------
  mem_state_e               state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] clear_ptr_q, clear_ptr_d;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_RST;
      clear_ptr_q <= '0;
    end else begin
      state_q     <= state_d;
      clear_ptr_q <= clear_ptr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clear_ptr_d = clear_ptr_q;
    unique case (state_q)
      ST_RST: begin
        clear_ptr_d = '0;
        state_d     = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      end
      ST_CLEAR: begin
        clear_ptr_d = clear_ptr_q + 1'b1;
        // The edge that zeroes the last word is also the edge into RUN.
        if (clear_ptr_q == LAST_ADDR) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RST;
      end
    endcase
  end

  logic clear_we;
  logic wr_req;
  logic rd_req;

  assign READY    = (state_q == ST_RUN);
  assign clear_we = (state_q == ST_CLEAR);
  assign wr_req   = READY && WRITE_ENABLE;
  assign rd_req   = READY && READ_ENABLE;

  // ---------------------------------------------------------------------------
  // Storage array. Not reset: contents survive RESET until the sweep runs.
  // ---------------------------------------------------------------------------
  logic [MEMORY_WIDTH-1:0] mem_q [MEMORY_DEPTH];

  always_ff @(posedge CLK) begin
    if (clear_we) begin
      mem_q[clear_ptr_q] <= '0;
    end else if (wr_req) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (BYTE_ENABLE[i]) begin
          mem_q[WRITE_ADDRESS][i*BYTE_WIDTH +: BYTE_WIDTH] <= DATA_IN[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read port: first stage lives here so the collision mux can pick between
  // the stored word and the word as it will look after this cycle's write.
  // ---------------------------------------------------------------------------
  logic [MEMORY_WIDTH-1:0] rd_word;
  logic [MEMORY_WIDTH-1:0] merged_word;
  logic                    collision;
  logic [MEMORY_WIDTH-1:0] s1_dat_d;
  logic [MEMORY_WIDTH-1:0] s1_dat_q;
  logic                    s1_vld_q;

  always_comb begin
    rd_word     = mem_q[READ_ADDRESS];
    merged_word = rd_word;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (BYTE_ENABLE[i]) begin
        merged_word[i*BYTE_WIDTH +: BYTE_WIDTH] = DATA_IN[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  assign collision = wr_req && rd_req && (WRITE_ADDRESS == READ_ADDRESS);
  assign s1_dat_d  = (WRITE_FIRST_MODE && collision) ? merged_word : rd_word;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      s1_vld_q <= 1'b0;
      s1_dat_q <= '0;
    end else begin
      s1_vld_q <= rd_req;
      if (rd_req) begin
        s1_dat_q <= s1_dat_d;
      end
    end
  end

  logic                    pipe_vld;
  logic [MEMORY_WIDTH-1:0] pipe_dat;

  if (READ_LATENCY > 1) begin : g_pipe
    memory_read_pipeline #(
      .WIDTH  (MEMORY_WIDTH),
      .STAGES (READ_LATENCY - 1)
    ) u_read_pipeline (
      .clk_i (CLK),
      .rst_i (RESET),
      .vld_i (s1_vld_q),
      .dat_i (s1_dat_q),
      .vld_o (pipe_vld),
      .dat_o (pipe_dat)
    );
  end else begin : g_no_pipe
    assign pipe_vld = s1_vld_q;
    assign pipe_dat = s1_dat_q;
  end

  // Pipeline data registers are not reset, so until the first response after
  // reset the output is forced to zero instead of showing stale words.
  logic out_live_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      out_live_q <= 1'b0;
    end else if (pipe_vld) begin
      out_live_q <= 1'b1;
    end
  end

  assign DATA_OUT       = (out_live_q || pipe_vld) ? pipe_dat : '0;
  assign DATA_OUT_VALID = pipe_vld;

endmodule

// File: tb/tb_byte_enable_dual_port_memory.sv
// Scoreboard bench: three instances (latency 1/WRITE_FIRST, 2/READ_FIRST,
// 3/WRITE_FIRST) share one stimulus stream; a monitor checks every response.
module tb_byte_enable_dual_port_memory;

  localparam string CM_WF = "WRITE_FIRST";
  localparam string CM_RF = "READ_FIRST";

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  wa;
  logic [31:0] din;
  logic        we;
  logic [3:0]  be;
  logic [3:0]  ra;
  logic        re;

  logic [31:0] dout [3];
  logic        dvld [3];
  logic        drdy [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    byte_enable_dual_port_memory #(
      .MEMORY_WIDTH   (32),
      .MEMORY_DEPTH   (16),
      .BYTE_WIDTH     (8),
      .READ_LATENCY   (g + 1),
      .COLLISION_MODE ((g == 1) ? CM_RF : CM_WF),
      .CLEAR_ON_RESET (1'b1),
      .INIT_FILE      ("")
    ) u_dut (
      .CLK            (clk),
      .RESET          (rst),
      .WRITE_ADDRESS  (wa),
      .DATA_IN        (din),
      .WRITE_ENABLE   (we),
      .BYTE_ENABLE    (be),
      .READ_ADDRESS   (ra),
      .READ_ENABLE    (re),
      .DATA_OUT       (dout[g]),
      .DATA_OUT_VALID (dvld[g]),
      .READY          (drdy[g])
    );
  end

  typedef struct {
    int          edge_n;  // edge at which the read is sampled
    logic [31:0] wf;      // expected word in WRITE_FIRST mode
    logic [31:0] rf;      // expected word in READ_FIRST mode
    int          gen;     // reset generation the read belongs to
  } exp_t;

  exp_t        exp_q [$];
  int          rd_idx [3];
  logic [31:0] last_dout [3];
  int          cyc = 0;
  int          gen = 0;
  logic        exp_rdy = 1'b0;
  logic        done = 1'b0;
  int          chk_cnt = 0;
  int          pass_cnt = 0;

  logic [31:0] sweep_dat [8] = '{32'h0000_0001, 32'h8000_0000, 32'hDEAD_BEEF, 32'h0123_4567,
                                 32'hFFFF_0000, 32'h5A5A_A5A5, 32'h0F0F_F0F0, 32'hCAFE_F00D};

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------- stimulus
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [31:0] d, input logic [3:0] m);
    we = 1'b1; wa = 4'(a); din = d; be = m;
  endtask

  task automatic rd(input int a, input logic [31:0] wf, input logic [31:0] rf);
    re = 1'b1; ra = 4'(a);
    exp_q.push_back('{cyc + 1, wf, rf, gen});
  endtask

  initial begin
    rst = 1'b0; we = 1'b0; re = 1'b0; be = '0; wa = '0; ra = '0; din = '0;
    #2 rst = 1'b1;
    repeat (3) step();

    // Stray write/read requests stay asserted through both sweeps.
    wr(2, 32'h1234_5678, 4'hF);
    rst = 1'b0;
    step();                       // RST -> CLEAR
    repeat (7) step();            // clear pointer now at 7
    rst = 1'b1; gen++;
    repeat (2) step();
    rst = 1'b0;
    step();                       // restart sweep
    re = 1'b1; ra = 4'd2;         // no response may come from this
    repeat (16) step();
    exp_rdy = 1'b1; we = 1'b0; re = 1'b0;

    // Whole array reads back zero.
    for (int a = 0; a < 16; a++) begin
      rd(a, 32'h0, 32'h0); step();
    end
    re = 1'b0;

    // Byte-lane merge.
    wr(3, 32'hAABB_CCDD, 4'b1111); step();
    wr(3, 32'h1122_3344, 4'b0101); step();
    we = 1'b0;
    rd(3, 32'hAA22_CC44, 32'hAA22_CC44); step();
    re = 1'b0;

    // Same-address collisions, full and partial lane masks.
    wr(5, 32'hFFFF_FFFF, 4'hF); rd(5, 32'hFFFF_FFFF, 32'h0000_0000); step();
    we = 1'b0;                  rd(5, 32'hFFFF_FFFF, 32'hFFFF_FFFF); step();
    wr(5, 32'h0000_1234, 4'b0011); rd(5, 32'hFFFF_1234, 32'hFFFF_FFFF); step();
    we = 1'b0;                  rd(5, 32'hFFFF_1234, 32'hFFFF_1234); step();
    re = 1'b0;

    // Back-to-back writes, then back-to-back reads of 0..7.
    for (int i = 7; i >= 0; i--) begin
      wr(i, sweep_dat[i], 4'hF); step();
    end
    we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd(i, sweep_dat[i], sweep_dat[i]); step();
    end
    re = 1'b0;

    // In-flight read keeps its word despite a later write.
    rd(3, 32'h0123_4567, 32'h0123_4567); step();
    re = 1'b0;
    wr(3, 32'h9999_9999, 4'hF); step();
    we = 1'b0;
    rd(3, 32'h9999_9999, 32'h9999_9999); step();
    re = 1'b0;
    repeat (4) step();

    // Reset lands while a read is in flight: it must vanish.
    rd(1, 32'h8000_0000, 32'h8000_0000); step();
    re = 1'b0;
    rst = 1'b1; gen++; exp_rdy = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    repeat (16) step();
    exp_rdy = 1'b1;
    rd(3, 32'h0, 32'h0); step();
    rd(1, 32'h0, 32'h0); step();
    re = 1'b0;
    repeat (6) step();
    done = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

  // ----------------------------------------------------------------- monitor
  task automatic chk(input bit ok, input string name, input int g,
                     input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s dut%0d cycle %0d: got %h, expected %h", name, g, cyc, act, exp);
  endtask

  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [31:0] want;
    for (int g = 0; g < 3; g++) begin
      while (rd_idx[g] < exp_q.size() && exp_q[rd_idx[g]].gen != gen) rd_idx[g]++;
    end
    if (!done) begin
      for (int g = 0; g < 3; g++) begin
        chk(drdy[g] == exp_rdy, "ready", g, 32'(drdy[g]), 32'(exp_rdy));
        if (rst) begin
          chk(dvld[g] == 1'b0, "reset_valid", g, 32'(dvld[g]), 32'h0);
          chk(dout[g] == 32'h0, "reset_data", g, dout[g], 32'h0);
          last_dout[g] = 32'h0;
        end else if (dvld[g]) begin
          if (rd_idx[g] >= exp_q.size()) begin
            chk(1'b0, "unexpected_valid", g, dout[g], 32'h0);
          end else begin
            e = exp_q[rd_idx[g]];
            rd_idx[g]++;
            want = (g == 1) ? e.rf : e.wf;
            chk(dout[g] == want, "read_data", g, dout[g], want);
            chk(cyc == e.edge_n + g, "latency", g, 32'(cyc), 32'(e.edge_n + g));
          end
          last_dout[g] = dout[g];
        end else begin
          chk(dout[g] == last_dout[g], "hold", g, dout[g], last_dout[g]);
        end
      end
    end else begin
      for (int g = 0; g < 3; g++) begin
        chk(rd_idx[g] == exp_q.size(), "missing_responses", g,
            32'(exp_q.size() - rd_idx[g]), 32'h0);
      end
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
    end
  end

endmodule
